// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: FSM states, fault codes,
// RV32 load/store funct3 values and the request fault classifier.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal funct3 outranks misalignment; a write request is classified with
  // the store rules even when a load is requested in the same cycle.
  function automatic logic [1:0] classify_fault(input logic       is_write,
                                                input logic [2:0] f3,
                                                input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    if (is_write) legal = f3 inside {F3_B, F3_H, F3_W};
    else          legal = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misaligned = ((f3 == F3_H || f3 == F3_HU) && addr_lo[0]) ||
                 ((f3 == F3_W) && (addr_lo != 2'b00));
    if (!legal)         return FAULT_ILLEGAL;
    else if (misaligned) return FAULT_MISALIGN;
    else                return FAULT_NONE;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request bus between the load/store unit (master) and the data
// memory (slave).
interface mem_access_unit_if;
  // Handshake: the master holds MEM_READ or MEM_WRITE together with FUNCT3,
  // ADDRESS and WRITEDATA stable until it samples MEM_BUSYWAIT low on a rising
  // edge after the request cycle; that edge completes the access and
  // MEM_READDATA is taken on the same edge for reads.
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  MEM_FUNCT3;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport master (
    output MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of a little-endian memory word according to the load
// funct3; shared with the cache-fill path.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (funct3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_W:    result = word;
      F3_BU:   result = {24'd0, word[7:0]};
      F3_HU:   result = {16'd0, word[15:0]};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: stalls the pipeline across each data-memory
// access, extends load data and reports misaligned/illegal/timeout faults.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data_i,
  output logic              stall_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic [1:0]        fault_o,
  output mem_state_t        state_o,
  mem_access_unit_if.master mem
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  mem_state_t  state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [31:0] rdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        load_valid_q;
  logic        timeout_q;

  logic        req_seen;
  logic [1:0]  comb_fault;
  logic        accept;
  logic [31:0] ext_word;

  assign req_seen   = mem_read_i | mem_write_i;
  assign comb_fault = classify_fault(mem_write_i, funct3_i, addr_i[1:0]);
  assign accept     = (state == ST_IDLE) && req_seen && (comb_fault == FAULT_NONE);
  assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      req_f3       <= 3'd0;
      req_addr     <= 32'd0;
      req_wdata    <= 32'd0;
      req_write    <= 1'b0;
      rdata_q      <= 32'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      load_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_f3      <= funct3_i;
            req_addr    <= addr_i;
            req_wdata   <= store_data_i;
            // A simultaneous read and write request performs only the write.
            req_write   <= mem_write_i;
            mem_read_q  <= ~mem_write_i;
            mem_write_q <= mem_write_i;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cnt   <= 8'd0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!mem.MEM_BUSYWAIT) begin
            if (!req_write) rdata_q <= mem.MEM_READDATA;
            load_valid_q <= ~req_write;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            state        <= ST_DONE;
          end else begin
            cnt <= cnt_inc;
            // cnt_inc is the number of busy WAIT edges seen including this one.
            if (cnt_inc >= TIMEOUT_LIM) begin
              timeout_q   <= 1'b1;
              mem_read_q  <= 1'b0;
              mem_write_q <= 1'b0;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          load_valid_q <= 1'b0;
          timeout_q    <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  load_extend u_load_extend (
    .funct3 (req_f3),
    .word   (rdata_q),
    .result (ext_word)
  );

  // RESET gates the combinational outputs so an asynchronous reset clears
  // them even while the pipeline is still presenting a request.
  assign stall_o = ~RESET & (accept || state == ST_ACCESS || state == ST_WAIT);

  always_comb begin
    fault_o = FAULT_NONE;
    if (!RESET) begin
      if (state == ST_IDLE && req_seen)       fault_o = comb_fault;
      else if (state == ST_DONE && timeout_q) fault_o = FAULT_TIMEOUT;
    end
  end

  assign load_valid_o      = load_valid_q;
  assign load_data_o       = load_valid_q ? ext_word : 32'd0;
  assign state_o           = state;

  assign mem.MEM_READ      = mem_read_q;
  assign mem.MEM_WRITE     = mem_write_q;
  assign mem.MEM_FUNCT3    = req_f3;
  assign mem.MEM_ADDRESS   = req_addr;
  assign mem.MEM_WRITEDATA = req_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (long and short timeout) share one
// stimulus stream; a selector picks which one is being checked.
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int T_LONG  = 255;
  localparam int T_SHORT = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic [31:0] rdata;
  logic        busy;
  logic        sel;

  mem_access_unit_if bus_a ();
  mem_access_unit_if bus_b ();
  assign bus_a.MEM_READDATA = rdata;
  assign bus_a.MEM_BUSYWAIT = busy;
  assign bus_b.MEM_READDATA = rdata;
  assign bus_b.MEM_BUSYWAIT = busy;

  logic        stall_a, stall_b, lv_a, lv_b;
  logic [31:0] ld_a, ld_b;
  logic [1:0]  f_a, f_b;
  mem_state_t  st_a, st_b;

  mem_access_unit #(.TIMEOUT_CYCLES(T_LONG)) dut_a (
    .CLK(CLK), .RESET(RESET), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .stall_o(stall_a), .load_data_o(ld_a), .load_valid_o(lv_a), .fault_o(f_a),
    .state_o(st_a), .mem(bus_a.master)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(T_SHORT)) dut_b (
    .CLK(CLK), .RESET(RESET), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .stall_o(stall_b), .load_data_o(ld_b), .load_valid_o(lv_b), .fault_o(f_b),
    .state_o(st_b), .mem(bus_b.master)
  );

  logic        o_stall, o_lv, o_read, o_write;
  logic [31:0] o_ld, o_addr, o_wdata;
  logic [2:0]  o_f3;
  logic [1:0]  o_fault;
  mem_state_t  o_state;
  assign o_stall = sel ? stall_b : stall_a;
  assign o_lv    = sel ? lv_b : lv_a;
  assign o_ld    = sel ? ld_b : ld_a;
  assign o_fault = sel ? f_b : f_a;
  assign o_state = sel ? st_b : st_a;
  assign o_read  = sel ? bus_b.MEM_READ : bus_a.MEM_READ;
  assign o_write = sel ? bus_b.MEM_WRITE : bus_a.MEM_WRITE;
  assign o_addr  = sel ? bus_b.MEM_ADDRESS : bus_a.MEM_ADDRESS;
  assign o_wdata = sel ? bus_b.MEM_WRITEDATA : bus_a.MEM_WRITEDATA;
  assign o_f3    = sel ? bus_b.MEM_FUNCT3 : bus_a.MEM_FUNCT3;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_fault(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int  f;
    bit  legal;
    f = int'(f3);
    if (wr) legal = (f <= 2);
    else    legal = (f <= 2) || (f == 4) || (f == 5);
    if (!legal) return 2'b10;
    if ((f == 1 || f == 5) && (a % 2 != 0)) return 2'b01;
    if (f == 2 && (a % 4 != 0)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w);
    longint b, h;
    b = longint'(w % 256);
    h = longint'(w % 65536);
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd2:    return w;
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Entered and left just after a rising edge. k = number of cycles, counted
  // from the ACCESS cycle, for which the responder holds BUSYWAIT high.
  task automatic do_access(input string tag, input bit rd, input bit wr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rw, input int k,
                           input logic [1:0] ef, input logic [31:0] ed,
                           output int wcyc);
    int  b, done, tmo;
    bit  to, is_w;
    logic [31:0] e;
    wcyc = 0;
    is_w = wr;
    tmo  = sel ? T_SHORT : T_LONG;
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a;
    store_data_i = wd; rdata = rw; busy = 1'b0;
    @(negedge CLK);
    chk({tag, " idle fault"}, 32'(o_fault), 32'(ef));
    chk({tag, " idle stall"}, 32'(o_stall), 32'((rd || wr) && ef == 2'b00));
    @(posedge CLK); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'($urandom_range(0, 7)); addr_i = $urandom; store_data_i = $urandom;
    if (ef != 2'b00 || !(rd || wr)) begin
      @(negedge CLK);
      chk({tag, " no access read"}, 32'(o_read), 32'd0);
      chk({tag, " no access write"}, 32'(o_write), 32'd0);
      chk({tag, " no access state"}, 32'(o_state), 32'(ST_IDLE));
      @(posedge CLK); #1;
      return;
    end
    if (!is_w) exp_q.push_back(ed);
    b    = (k > 1) ? k - 1 : 0;
    to   = (b >= tmo);
    done = to ? 2 + tmo : 3 + b;
    for (int c = 1; c <= done; c++) begin
      busy = (c <= k);
      if (c == done) begin
        mem_read_i = 1'($urandom_range(0, 1)); mem_write_i = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
      if (o_write) wcyc++;
      if (c < done) begin
        chk({tag, " state"}, 32'(o_state), (c == 1) ? 32'(ST_ACCESS) : 32'(ST_WAIT));
        chk({tag, " stall"}, 32'(o_stall), 32'd1);
        chk({tag, " mem read"}, 32'(o_read), 32'(!is_w));
        chk({tag, " mem write"}, 32'(o_write), 32'(is_w));
        chk({tag, " mem addr"}, o_addr, a);
        chk({tag, " mem funct3"}, 32'(o_f3), 32'(f3));
        chk({tag, " mem wdata"}, o_wdata, wd);
        chk({tag, " early valid"}, 32'(o_lv), 32'd0);
      end else begin
        chk({tag, " done state"}, 32'(o_state), 32'(ST_DONE));
        chk({tag, " done stall"}, 32'(o_stall), 32'd0);
        chk({tag, " done read"}, 32'(o_read), 32'd0);
        chk({tag, " done write"}, 32'(o_write), 32'd0);
        chk({tag, " done fault"}, 32'(o_fault), to ? 32'd3 : 32'd0);
        chk({tag, " done valid"}, 32'(o_lv), 32'(!is_w && !to));
        chk({tag, " done addr held"}, o_addr, a);
        if (!is_w) begin
          e = exp_q.pop_front();
          chk({tag, " load data"}, o_ld, to ? 32'd0 : e);
        end else begin
          chk({tag, " store load data"}, o_ld, 32'd0);
        end
      end
      @(posedge CLK); #1;
    end
    mem_read_i = 1'b0; mem_write_i = 1'b0; busy = 1'b0;
  endtask

  task automatic resync();
    RESET = 1'b1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; busy = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rw;
    int          k;
    logic [1:0]  ef;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int          wc;
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, rw;
    logic [1:0]  ef;

    tbl[0]  = '{1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2'b00, 32'hDEADBEEF};
    tbl[1]  = '{1, 0, 3'b000, 32'h31, 32'h0, 32'h00000080, 1, 2'b00, 32'hFFFFFF80};
    tbl[2]  = '{1, 0, 3'b100, 32'h31, 32'h0, 32'h00000080, 2, 2'b00, 32'h00000080};
    tbl[3]  = '{1, 0, 3'b001, 32'h42, 32'h0, 32'h00008001, 0, 2'b00, 32'hFFFF8001};
    tbl[4]  = '{1, 0, 3'b101, 32'h42, 32'h0, 32'h00008001, 3, 2'b00, 32'h00008001};
    tbl[5]  = '{1, 0, 3'b010, 32'h22, 32'h0, 32'h11111111, 0, 2'b01, 32'h0};
    tbl[6]  = '{0, 1, 3'b011, 32'h20, 32'h5, 32'h0, 0, 2'b10, 32'h0};
    tbl[7]  = '{0, 1, 3'b001, 32'h33, 32'h5, 32'h0, 0, 2'b01, 32'h0};
    tbl[8]  = '{1, 0, 3'b011, 32'h03, 32'h0, 32'h0, 0, 2'b10, 32'h0};
    tbl[9]  = '{1, 1, 3'b100, 32'h08, 32'h7, 32'h0, 0, 2'b10, 32'h0};
    tbl[10] = '{1, 1, 3'b010, 32'h50, 32'hCAFEF00D, 32'h0, 1, 2'b00, 32'h0};
    tbl[11] = '{1, 0, 3'b010, 32'h64, 32'h0, 32'h0BADC0DE, 4, 2'b00, 32'h0BADC0DE};
    tbl[12] = '{1, 0, 3'b101, 32'h06, 32'h0, 32'hFFFF7FFF, 0, 2'b00, 32'h00007FFF};
    tbl[13] = '{1, 0, 3'b001, 32'h06, 32'h0, 32'h1234F00F, 0, 2'b00, 32'hFFFFF00F};
    tbl[14] = '{1, 0, 3'b000, 32'h02, 32'h0, 32'hAAAAAA7F, 2, 2'b00, 32'h0000007F};
    tbl[15] = '{0, 1, 3'b101, 32'h00, 32'h9, 32'h0, 0, 2'b10, 32'h0};

    sel = 1'b0; RESET = 1'b1; busy = 1'b0; rdata = 32'd0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'd0; addr_i = 32'd0; store_data_i = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset stall", 32'(o_stall), 32'd0);
    chk("reset fault", 32'(o_fault), 32'd0);
    chk("reset valid", 32'(o_lv), 32'd0);
    chk("reset load data", o_ld, 32'd0);
    chk("reset mem read", 32'(o_read), 32'd0);
    chk("reset mem write", 32'(o_write), 32'd0);
    chk("reset mem addr", o_addr, 32'd0);
    chk("reset mem funct3", 32'(o_f3), 32'd0);
    chk("reset mem wdata", o_wdata, 32'd0);
    chk("reset state", 32'(o_state), 32'(ST_IDLE));
    @(posedge CLK); #1;
    RESET = 1'b0;

    for (int i = 0; i < 16; i++)
      do_access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a,
                tbl[i].wd, tbl[i].rw, tbl[i].k, tbl[i].ef, tbl[i].ed, wc);

    // Random accesses; at most 3 busy WAIT cycles so both instances stay in step.
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 2) == 0);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      rw = $urandom;
      ef = (rd || wr) ? ref_fault(wr, f3, a) : 2'b00;
      do_access($sformatf("rnd%0d", i), rd, wr, f3, a, wd, rw, $urandom_range(0, 4),
                ef, wr ? 32'd0 : ref_load(f3, rw), wc);
    end

    // Store with BUSYWAIT held 5 cycles from ACCESS.
    do_access("sw wait5", 1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 5, 2'b00, 32'h0, wc);
    chk("sw wait5 write cycles", 32'(wc), 32'd6);
    resync();

    // Timeout on the short-timeout instance with BUSYWAIT stuck high.
    sel = 1'b1;
    do_access("timeout", 1'b1, 1'b0, 3'b010, 32'h60, 32'h0, 32'h55AA55AA, 40, 2'b00,
              32'h55AA55AA, wc);
    sel = 1'b0;
    resync();

    // Asynchronous reset while a load waits, then a normal load.
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40; busy = 1'b1;
    @(posedge CLK); #1;
    mem_read_i = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pre-reset state", 32'(o_state), 32'(ST_WAIT));
    chk("pre-reset read", 32'(o_read), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("async reset read", 32'(o_read), 32'd0);
    chk("async reset stall", 32'(o_stall), 32'd0);
    chk("async reset state", 32'(o_state), 32'(ST_IDLE));
    #1 RESET = 1'b0;
    busy = 1'b0;
    @(posedge CLK); #1;
    do_access("post-reset lw", 1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h13579BDF, 1, 2'b00,
              32'h13579BDF, wc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
